// File: rtl/seq_divider8.sv
// Sequential restoring divider: one quotient bit per cycle, zero divisors resolved
// immediately with a saturated quotient and a div_by_zero flag.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation are held
// RUN   | one shift-subtract step per cycle, bit counter counts down to 1
// DONE  | results valid, done pulses; start here launches the next divide
module seq_divider8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part_rem, dvd, dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_step, dvd_step;
    logic             accept, last_step;

    // The shifted partial remainder is one bit wider than the divisor, so the
    // trial subtraction keeps an extra borrow bit that serves as the sign.
    always_comb begin
        shifted  = {part_rem, dvd[WIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, dvs};
        borrow   = trial[WIDTH+1];
        rem_step = borrow ? shifted[WIDTH-1:0] : WIDTH'(trial);
        dvd_step = {dvd[WIDTH-2:0], ~borrow};
    end

    assign last_step = (count == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (in_b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (in_b == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            part_rem    <= '0;
            dvd         <= '0;
            dvs         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (in_b == '0) begin
                quotient    <= '1;
                remainder   <= in_a;
                div_by_zero <= 1'b1;
                count       <= '0;
            end else begin
                dvd      <= in_a;
                dvs      <= in_b;
                part_rem <= '0;
                count    <= CW'(WIDTH);
            end
        end else if (state == RUN) begin
            part_rem <= rem_step;
            dvd      <= dvd_step;
            count    <= count - CW'(1);
            if (last_step) begin
                quotient    <= dvd_step;
                remainder   <= rem_step;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider8.sv
// Directed bench for seq_divider8: expected results are queued at issue time and
// checked, including their arrival cycle, by an independent monitor on done.
`timescale 1ns/1ps
module tb_seq_divider8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] in_a, in_b;
    logic [7:0] quotient, remainder;
    logic       busy, done, div_by_zero;

    typedef struct {
        int q;
        int r;
        int z;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    seq_divider8 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .in_b(in_b),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("quotient", int'(quotient), e.q);
                chk("remainder", int'(remainder), e.r);
                chk("div_by_zero", int'(div_by_zero), e.z);
            end
        end
    end

    // Call at a negedge: start is seen by the next rising edge (cycle 0 = cyc now).
    task automatic launch(input int a, input int b, input int q, input int r, input int z);
        exp_t e;
        start = 1'b1;
        in_a  = 8'(a);
        in_b  = 8'(b);
        e.q = q; e.r = r; e.z = z;
        e.cyc = cyc + ((b == 0) ? 1 : 9);
        sb.push_back(e);
    endtask

    task automatic scramble();
        start = 1'b0;
        in_a  = 8'($urandom);
        in_b  = 8'($urandom);
    endtask

    // Single operation with busy profile and result hold checks.
    task automatic run(input int a, input int b, input int q, input int r, input int z);
        launch(a, b, q, r, z);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) scramble();
            chk("busy", int'(busy), (b != 0 && i <= 8) ? 1 : 0);
        end
        chk("hold_quotient", int'(quotient), q);
        chk("hold_remainder", int'(remainder), r);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in_a  = 8'd0;
        in_b  = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(100, 7, 14, 2, 0);
        run(255, 1, 255, 0, 0);
        run(3, 10, 0, 3, 0);
        run(255, 255, 1, 0, 0);
        run(5, 0, 255, 5, 1);
        run(0, 5, 0, 0, 0);
        run(254, 16, 15, 14, 0);

        // start during RUN must be ignored
        launch(200, 9, 22, 2, 0);
        @(negedge clk); scramble();
        repeat (3) @(negedge clk);
        start = 1'b1; in_a = 8'd1; in_b = 8'd1;
        @(negedge clk); scramble();
        chk("busy_after_ignored_start", int'(busy), 1);
        repeat (6) @(negedge clk);

        // back-to-back: second start in the done cycle
        launch(50, 6, 8, 2, 0);
        @(negedge clk); scramble();
        repeat (8) @(negedge clk);
        chk("done_before_b2b", int'(done), 1);
        launch(77, 8, 9, 5, 0);
        @(negedge clk); scramble();
        chk("busy_b2b", int'(busy), 1);
        repeat (10) @(negedge clk);

        // reset mid-run aborts the operation
        launch(100, 7, 14, 2, 0);
        @(negedge clk); scramble();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_dbz", int'(div_by_zero), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run(100, 7, 14, 2, 0);

        repeat (3) @(negedge clk);
        chk("pending_results", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider8.md
SEQ_DIVIDER8 -- requirements
Module: seq_divider8

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; only 8 is verified.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low; when low, all registers are forced to reset values immediately.
REQ-004 start  input  1  request: launches a divide when sampled high while the block accepts a new operation.
REQ-005 in_a  input  WIDTH  dividend, unsigned; sampled only on an accepted start.
REQ-006 in_b  input  WIDTH  divisor, unsigned; sampled only on an accepted start.
REQ-007 quotient  output  WIDTH  registered quotient; valid from done until the next accepted start.
REQ-008 remainder  output  WIDTH  registered remainder; valid from done until the next accepted start.
REQ-009 busy  output  1  high while in state RUN.
REQ-010 done  output  1  one-cycle pulse marking valid results.
REQ-011 div_by_zero  output  1  high with done when the latched divisor was 0; held with the results.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1, in_b!=0: latch in_a and in_b, clear the partial remainder, load bit counter = WIDTH, go to RUN.
REQ-014 IDLE with start=1, in_b=0: go directly to DONE; quotient = all ones, remainder = in_a, div_by_zero = 1.
REQ-015 RUN performs one restoring shift-subtract step per cycle.
- Shift {partial remainder, dividend} left one bit.
- Form trial = partial remainder - divisor at WIDTH+1 bits.
- If trial is non-negative, keep trial and shift in quotient bit 1; otherwise restore and shift in quotient bit 0.
REQ-016 The subtraction SHALL be computed at WIDTH+1 bits, with the borrow as the sign, so that no divisor value up to 2^WIDTH-1 overflows.
REQ-017 RUN SHALL last exactly WIDTH cycles, then go to DONE with quotient = floor(a/b), remainder = a mod b, and div_by_zero = 0.
REQ-018 Latency: with start sampled in cycle 0, done SHALL be high in cycle WIDTH+1 (cycle 9 for WIDTH=8); for a zero divisor it SHALL be high in cycle 1.
REQ-019 done SHALL be high only in state DONE, for exactly one cycle per operation.
REQ-020 DONE SHALL go to IDLE when start=0.
REQ-021 DONE with start=1 SHALL accept a new operation per REQ-013/014 (back-to-back, no idle cycle).
REQ-022 start while in RUN SHALL be ignored: no operand capture, no effect on the running operation.
REQ-023 in_a and in_b changes after acceptance SHALL NOT affect the result.
REQ-024 quotient, remainder and div_by_zero SHALL update only on entry to DONE and hold their values until then.
REQ-025 A dividend smaller than the divisor SHALL yield quotient 0 and remainder = dividend.

Reset
REQ-026 rst_n low SHALL force state IDLE, busy 0, done 0, div_by_zero 0, quotient 0, remainder 0, and counter 0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation; no done is produced after reset release.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 in_a=100, in_b=7, start pulse in cycle 0 -> busy high in cycles 1-8; done in cycle 9; quotient=14, remainder=2, div_by_zero=0.
REQ-030 Operand pairs and required results:
- in_a=255, in_b=1 -> quotient=255, remainder=0.
- in_a=3, in_b=10 -> quotient=0, remainder=3.
- in_a=255, in_b=255 -> quotient=1, remainder=0.
REQ-031 in_a=5, in_b=0 -> done in cycle 1 with quotient=0xFF, remainder=5, div_by_zero=1; busy never high.
REQ-032 Start 200/9; in cycle 4 drive start=1 with in_a=1, in_b=1 -> ignored; cycle 9 gives quotient=22, remainder=2.
REQ-033 Start 50/6; drive start=1 with 77/8 in the done cycle -> first result 8 rem 2; second done 9 cycles later gives 9 rem 5.
REQ-034 Start 100/7; pull rst_n low in cycle 4 -> all outputs 0 immediately; no done after release; then 100/7 -> 14 rem 2 on schedule.
